// File: rtl/clock_pkg.sv
// Shared types and constants for the seconds-of-day clock blocks
// (counter, alarm, output and time-entry front end).
package clock_pkg;

  typedef logic [16:0] COUNTER_T;
  typedef logic        FLAG_T;
  typedef logic [5:0]  TIME_T;

  localparam COUNTER_T   COUNTER_MAX   = 17'd86399;
  localparam COUNTER_T   HOUR_TICK     = 17'd3600;
  localparam COUNTER_T   MIN_TICK      = 17'd60;
  localparam logic [3:0] HOUR_ROLLOVER = 4'd12;
  localparam COUNTER_T   AMPM_TICK     = 17'd43200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEC_H,
    ST_DEC_M,
    ST_EDIT_H,
    ST_EDIT_M,
    ST_EDIT_S,
    ST_EDIT_AP,
    ST_COMMIT
  } set_state_t;

  // Step a minute/second field by one, wrapping 59 <-> 0 with no carry.
  function automatic TIME_T step59(input TIME_T v, input logic up);
    TIME_T r;
    if (up) r = (v == 6'd59) ? 6'd0 : v + 6'd1;
    else    r = (v == 6'd0) ? 6'd59 : v - 6'd1;
    return r;
  endfunction

endpackage

// File: rtl/hms_encode.sv
// Combinational hour/min/sec/PM -> seconds-of-day encoder.
// Hour is the internal 0..11 value; PM adds half a day. Products are
// built from shifts so no multiplier is inferred.
module hms_encode
  import clock_pkg::*;
(
  input  logic [3:0]  i_hour,
  input  logic [5:0]  i_min,
  input  logic [5:0]  i_sec,
  input  logic        i_pm,
  output logic [16:0] o_secs
);

  COUNTER_T w_h;
  COUNTER_T w_m;
  COUNTER_T w_hour_secs;
  COUNTER_T w_min_secs;

  // 3600 = 2048 + 1024 + 512 + 16 ; 60 = 32 + 16 + 8 + 4
  always_comb begin
    w_h         = {13'd0, i_hour};
    w_m         = {11'd0, i_min};
    w_hour_secs = (w_h << 11) + (w_h << 10) + (w_h << 9) + (w_h << 4);
    w_min_secs  = (w_m << 5) + (w_m << 4) + (w_m << 3) + (w_m << 2);
    o_secs      = w_hour_secs + w_min_secs + {11'd0, i_sec}
                + (i_pm ? AMPM_TICK : 17'd0);
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-entry front end. A mode press decodes the clock or
// alarm value into editable fields by repeated subtraction, the user edits
// hour/min/sec/AM-PM, and the re-encoded value is handed to the counter
// (set_flag/set_time) or stored as the alarm setpoint.
module time_set_ctrl
  import clock_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_alarm_en,
  input  logic        target_sel,
  input  logic [16:0] counter_state,
  output logic        set_flag,
  output logic [16:0] set_time,
  output logic        alarm_flag,
  output logic [16:0] alarm_time,
  output logic [1:0]  edit_field,
  output logic [3:0]  edit_hour,
  output logic [5:0]  edit_min,
  output logic [5:0]  edit_sec,
  output logic        edit_pm
);

  set_state_t r_state;
  set_state_t w_next_state;

  logic     r_mode_prev, r_inc_prev, r_dec_prev, r_alarm_en_prev;
  logic     w_mode_edge, w_inc_edge, w_dec_edge, w_alarm_en_edge;
  logic     w_in_edit, w_inc_act, w_dec_act;

  FLAG_T    r_target;
  COUNTER_T r_work;
  logic [3:0] r_hour;
  TIME_T    r_min;
  TIME_T    r_sec;
  FLAG_T    r_pm;
  COUNTER_T r_set_time;
  COUNTER_T r_alarm_time;
  FLAG_T    r_alarm_flag;
  COUNTER_T w_enc;

  // Rising-edge detection; mode wins over inc/dec, inc+dec cancel out.
  always_comb begin
    w_mode_edge     = btn_mode & ~r_mode_prev;
    w_inc_edge      = btn_inc & ~r_inc_prev;
    w_dec_edge      = btn_dec & ~r_dec_prev;
    w_alarm_en_edge = btn_alarm_en & ~r_alarm_en_prev;
    w_in_edit       = (r_state == ST_EDIT_H) || (r_state == ST_EDIT_M) ||
                      (r_state == ST_EDIT_S) || (r_state == ST_EDIT_AP);
    w_inc_act       = w_in_edit & w_inc_edge & ~w_dec_edge & ~w_mode_edge;
    w_dec_act       = w_in_edit & w_dec_edge & ~w_inc_edge & ~w_mode_edge;
  end

  // Previous button levels for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mode_prev     <= 1'b0;
      r_inc_prev      <= 1'b0;
      r_dec_prev      <= 1'b0;
      r_alarm_en_prev <= 1'b0;
    end else begin
      r_mode_prev     <= btn_mode;
      r_inc_prev      <= btn_inc;
      r_dec_prev      <= btn_dec;
      r_alarm_en_prev <= btn_alarm_en;
    end
  end

  // Alarm enable toggles on its button regardless of the edit FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_alarm_flag <= 1'b0;
    else if (w_alarm_en_edge) r_alarm_flag <= ~r_alarm_flag;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state: decode loops exit once the remainder drops below a tick.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_mode_edge) w_next_state = ST_DEC_H;
      ST_DEC_H:   if (r_work < HOUR_TICK) w_next_state = ST_DEC_M;
      ST_DEC_M:   if (r_work < MIN_TICK) w_next_state = ST_EDIT_H;
      ST_EDIT_H:  if (w_mode_edge) w_next_state = ST_EDIT_M;
      ST_EDIT_M:  if (w_mode_edge) w_next_state = ST_EDIT_S;
      ST_EDIT_S:  if (w_mode_edge) w_next_state = ST_EDIT_AP;
      ST_EDIT_AP: if (w_mode_edge) w_next_state = ST_COMMIT;
      ST_COMMIT:  w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  hms_encode u_encode (
    .i_hour (r_hour),
    .i_min  (r_min),
    .i_sec  (r_sec),
    .i_pm   (r_pm),
    .o_secs (w_enc)
  );

  // Decode loop and field editing. Hour is kept as 0..11 and PM separately,
  // so counting hours past 11 during decode flips to PM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_target <= 1'b0;
      r_work   <= '0;
      r_hour   <= '0;
      r_min    <= '0;
      r_sec    <= '0;
      r_pm     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mode_edge) begin
            r_target <= target_sel;
            r_work   <= target_sel ? r_alarm_time : counter_state;
            r_hour   <= '0;
            r_min    <= '0;
            r_sec    <= '0;
            r_pm     <= 1'b0;
          end
        end
        ST_DEC_H: begin
          if (r_work >= HOUR_TICK) begin
            r_work <= r_work - HOUR_TICK;
            if (r_hour == HOUR_ROLLOVER - 4'd1) begin
              r_hour <= '0;
              r_pm   <= 1'b1;
            end else begin
              r_hour <= r_hour + 4'd1;
            end
          end
        end
        ST_DEC_M: begin
          if (r_work >= MIN_TICK) begin
            r_work <= r_work - MIN_TICK;
            r_min  <= r_min + 6'd1;
          end else begin
            r_sec  <= r_work[5:0];
          end
        end
        ST_EDIT_H: begin
          if (w_inc_act)
            r_hour <= (r_hour == HOUR_ROLLOVER - 4'd1) ? 4'd0 : r_hour + 4'd1;
          else if (w_dec_act)
            r_hour <= (r_hour == 4'd0) ? HOUR_ROLLOVER - 4'd1 : r_hour - 4'd1;
        end
        ST_EDIT_M: begin
          if (w_inc_act || w_dec_act) r_min <= step59(r_min, w_inc_act);
        end
        ST_EDIT_S: begin
          if (w_inc_act || w_dec_act) r_sec <= step59(r_sec, w_inc_act);
        end
        ST_EDIT_AP: begin
          if (w_inc_act || w_dec_act) r_pm <= ~r_pm;
        end
        default: ;
      endcase
    end
  end

  // Output registers: set_time tracks the edited value each edit cycle for
  // the clock target; the alarm setpoint changes only on commit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_set_time   <= '0;
      r_alarm_time <= '0;
    end else begin
      if (r_state == ST_IDLE && w_mode_edge && !target_sel)
        r_set_time <= counter_state;
      else if (w_in_edit && !r_target)
        r_set_time <= w_enc;
      else if (r_state == ST_COMMIT && !r_target)
        r_set_time <= w_enc;

      if (r_state == ST_COMMIT && r_target)
        r_alarm_time <= w_enc;
    end
  end

  // Display/handshake outputs derived from state and field registers.
  always_comb begin
    set_flag   = (r_state != ST_IDLE) && !r_target;
    set_time   = r_set_time;
    alarm_flag = r_alarm_flag;
    alarm_time = r_alarm_time;
    edit_hour  = (r_hour == 4'd0) ? HOUR_ROLLOVER : r_hour;
    edit_min   = r_min;
    edit_sec   = r_sec;
    edit_pm    = r_pm;
    case (r_state)
      ST_EDIT_M:  edit_field = 2'd1;
      ST_EDIT_S:  edit_field = 2'd2;
      ST_EDIT_AP: edit_field = 2'd3;
      default:    edit_field = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: decode, edit, commit, wraps,
// simultaneous button edges and asynchronous reset.
module tb_time_set_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_alarm_en = 1'b0;
  logic        target_sel = 1'b0;
  logic [16:0] counter_state = '0;
  logic        set_flag;
  logic [16:0] set_time;
  logic        alarm_flag;
  logic [16:0] alarm_time;
  logic [1:0]  edit_field;
  logic [3:0]  edit_hour;
  logic [5:0]  edit_min;
  logic [5:0]  edit_sec;
  logic        edit_pm;

  int n_checks = 0;
  int n_fail   = 0;
  logic alarm_phase = 1'b0;
  logic sf_seen = 1'b0;

  time_set_ctrl dut (
    .clock(clock), .reset_n(reset_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .btn_alarm_en(btn_alarm_en), .target_sel(target_sel),
    .counter_state(counter_state), .set_flag(set_flag), .set_time(set_time),
    .alarm_flag(alarm_flag), .alarm_time(alarm_time), .edit_field(edit_field),
    .edit_hour(edit_hour), .edit_min(edit_min), .edit_sec(edit_sec), .edit_pm(edit_pm)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (alarm_phase && set_flag === 1'b1) sf_seen = 1'b1;

  task automatic press(input logic m, input logic i, input logic d, input logic a);
    @(negedge clock);
    btn_mode = m; btn_inc = i; btn_dec = d; btn_alarm_en = a;
    @(negedge clock);
    btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_alarm_en = 0;
    @(negedge clock);
  endtask

  task automatic start_edit(input logic sel, input logic [16:0] cs);
    counter_state = cs;
    target_sel = sel;
    press(1, 0, 0, 0);
    repeat (90) @(negedge clock);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (set_flag !== 1'b0) begin n_fail++; $display("FAIL reset_set_flag: got %0d expected 0", set_flag); end
    n_checks++; if (set_time !== 17'd0) begin n_fail++; $display("FAIL reset_set_time: got %0d expected 0", set_time); end
    n_checks++; if (alarm_time !== 17'd0) begin n_fail++; $display("FAIL reset_alarm_time: got %0d expected 0", alarm_time); end
    n_checks++; if (alarm_flag !== 1'b0) begin n_fail++; $display("FAIL reset_alarm_flag: got %0d expected 0", alarm_flag); end
    n_checks++; if (edit_hour !== 4'd12) begin n_fail++; $display("FAIL reset_edit_hour: got %0d expected 12", edit_hour); end
    n_checks++; if ({edit_field, edit_min, edit_sec, edit_pm} !== 15'd0) begin n_fail++; $display("FAIL reset_fields: field %0d min %0d sec %0d pm %0d expected all 0", edit_field, edit_min, edit_sec, edit_pm); end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_decode_latency;
    int cyc;
    logic found;
    counter_state = 17'd34953;
    target_sel = 1'b0;
    @(negedge clock);
    btn_mode = 1'b1;
    @(posedge clock);
    cyc = 0; found = 1'b0;
    while (!found && cyc < 200) begin
      @(posedge clock);
      cyc++;
      #1;
      if (cyc == 1) btn_mode = 1'b0;
      if (cyc == 20) begin
        n_checks++; if (set_flag !== 1'b1 || set_time !== 17'd34953) begin n_fail++; $display("FAIL decode_hold: set_flag %0d set_time %0d expected 1 34953", set_flag, set_time); end
      end
      if (edit_sec == 6'd33) found = 1'b1;
    end
    n_checks++; if (!found || cyc != 53) begin n_fail++; $display("FAIL decode_latency: got %0d cycles (found %0d) expected 53", cyc, found); end
    n_checks++; if (edit_hour !== 4'd9 || edit_min !== 6'd42 || edit_pm !== 1'b0) begin n_fail++; $display("FAIL decode_fields: got %0d:%0d pm %0d expected 9:42 pm 0", edit_hour, edit_min, edit_pm); end
    n_checks++; if (edit_field !== 2'd0 || set_flag !== 1'b1 || set_time !== 17'd34953) begin n_fail++; $display("FAIL decode_outputs: field %0d set_flag %0d set_time %0d expected 0 1 34953", edit_field, set_flag, set_time); end
  endtask

  task automatic test_edit_commit;
    logic [16:0] exp;
    exp = 17'(12 * 3600 + 42 * 60 + 59);
    repeat (3) press(0, 1, 0, 0);
    n_checks++; if (edit_hour !== 4'd12 || edit_pm !== 1'b0) begin n_fail++; $display("FAIL edit_hour_inc: got %0d pm %0d expected 12 pm 0", edit_hour, edit_pm); end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    n_checks++; if (edit_field !== 2'd2) begin n_fail++; $display("FAIL edit_field_sec: got %0d expected 2", edit_field); end
    repeat (34) press(0, 0, 1, 0);
    n_checks++; if (edit_sec !== 6'd59 || edit_min !== 6'd42) begin n_fail++; $display("FAIL edit_sec_dec: got sec %0d min %0d expected 59 42", edit_sec, edit_min); end
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    n_checks++; if (edit_pm !== 1'b1 || edit_field !== 2'd3) begin n_fail++; $display("FAIL edit_pm_toggle: got pm %0d field %0d expected 1 3", edit_pm, edit_field); end
    n_checks++; if (set_time !== exp) begin n_fail++; $display("FAIL edit_set_time_track: got %0d expected %0d", set_time, exp); end
    @(negedge clock);
    btn_mode = 1'b1;
    @(negedge clock);
    n_checks++; if (set_flag !== 1'b1) begin n_fail++; $display("FAIL commit_set_flag_high: got %0d expected 1", set_flag); end
    btn_mode = 1'b0;
    @(negedge clock);
    n_checks++; if (set_flag !== 1'b0 || set_time !== exp) begin n_fail++; $display("FAIL commit_exit: set_flag %0d set_time %0d expected 0 %0d", set_flag, set_time, exp); end
  endtask

  task automatic test_alarm_setup;
    logic [16:0] exp;
    exp = 17'(14 * 3600 + 8 * 60 + 45);
    alarm_phase = 1'b1; sf_seen = 1'b0;
    start_edit(1'b1, 17'd12345);
    n_checks++; if (edit_hour !== 4'd12 || edit_min !== 6'd0 || edit_sec !== 6'd0 || edit_pm !== 1'b0) begin n_fail++; $display("FAIL alarm_zero_decode: got %0d:%0d:%0d pm %0d expected 12:0:0 pm 0", edit_hour, edit_min, edit_sec, edit_pm); end
    repeat (2) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    repeat (8) press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    repeat (15) press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    n_checks++; if (alarm_time !== exp) begin n_fail++; $display("FAIL alarm_setup_commit: got %0d expected %0d", alarm_time, exp); end
    n_checks++; if (set_time !== 17'd45779) begin n_fail++; $display("FAIL alarm_set_time_kept: got %0d expected 45779", set_time); end
  endtask

  task automatic test_alarm_edit;
    logic [16:0] exp;
    exp = 17'(14 * 3600 + 9 * 60 + 45);
    start_edit(1'b1, 17'd0);
    target_sel = 1'b0;
    n_checks++; if (edit_hour !== 4'd2 || edit_min !== 6'd8 || edit_sec !== 6'd45 || edit_pm !== 1'b1) begin n_fail++; $display("FAIL alarm_decode: got %0d:%0d:%0d pm %0d expected 2:8:45 pm 1", edit_hour, edit_min, edit_sec, edit_pm); end
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    n_checks++; if (edit_min !== 6'd9) begin n_fail++; $display("FAIL alarm_min_inc: got %0d expected 9", edit_min); end
    repeat (3) press(1, 0, 0, 0);
    n_checks++; if (alarm_time !== exp) begin n_fail++; $display("FAIL alarm_commit: got %0d expected %0d", alarm_time, exp); end
    n_checks++; if (sf_seen !== 1'b0) begin n_fail++; $display("FAIL alarm_set_flag_seen: got %0d expected 0", sf_seen); end
    alarm_phase = 1'b0;
  endtask

  task automatic test_wraps;
    start_edit(1'b0, 17'(11 * 3600 + 59));
    n_checks++; if (edit_hour !== 4'd11 || edit_sec !== 6'd59) begin n_fail++; $display("FAIL wrap_decode: got hour %0d sec %0d expected 11 59", edit_hour, edit_sec); end
    press(0, 1, 0, 0);
    n_checks++; if (edit_hour !== 4'd12 || edit_pm !== 1'b0) begin n_fail++; $display("FAIL wrap_hour: got %0d pm %0d expected 12 pm 0", edit_hour, edit_pm); end
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    n_checks++; if (edit_min !== 6'd59 || edit_hour !== 4'd12) begin n_fail++; $display("FAIL wrap_min_dec: got min %0d hour %0d expected 59 12", edit_min, edit_hour); end
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    n_checks++; if (edit_sec !== 6'd0 || edit_min !== 6'd59) begin n_fail++; $display("FAIL wrap_sec_inc: got sec %0d min %0d expected 0 59", edit_sec, edit_min); end
    repeat (2) press(1, 0, 0, 0);
    n_checks++; if (set_time !== 17'(59 * 60) || set_flag !== 1'b0) begin n_fail++; $display("FAIL wrap_commit: set_time %0d set_flag %0d expected 3540 0", set_time, set_flag); end
  endtask

  task automatic test_simultaneous;
    start_edit(1'b0, 17'd34953);
    press(1, 0, 0, 0);
    press(0, 1, 1, 0);
    n_checks++; if (edit_min !== 6'd42 || edit_field !== 2'd1) begin n_fail++; $display("FAIL inc_dec_same: got min %0d field %0d expected 42 1", edit_min, edit_field); end
    press(1, 1, 0, 0);
    n_checks++; if (edit_field !== 2'd2 || edit_min !== 6'd42 || edit_sec !== 6'd33) begin n_fail++; $display("FAIL mode_beats_inc: got field %0d min %0d sec %0d expected 2 42 33", edit_field, edit_min, edit_sec); end
    press(0, 0, 0, 1);
    n_checks++; if (alarm_flag !== 1'b1 || edit_field !== 2'd2) begin n_fail++; $display("FAIL alarm_en_toggle: got flag %0d field %0d expected 1 2", alarm_flag, edit_field); end
    repeat (2) press(1, 0, 0, 0);
    n_checks++; if (set_flag !== 1'b0 || set_time !== 17'd34953) begin n_fail++; $display("FAIL simul_commit: set_flag %0d set_time %0d expected 0 34953", set_flag, set_time); end
  endtask

  task automatic test_reset_mid_dec;
    counter_state = 17'd34953;
    target_sel = 1'b0;
    @(negedge clock); btn_mode = 1'b1;
    @(negedge clock); btn_mode = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if (set_flag !== 1'b1) begin n_fail++; $display("FAIL mid_dec_active: got %0d expected 1", set_flag); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (set_flag !== 1'b0) begin n_fail++; $display("FAIL mid_reset_set_flag: got %0d expected 0", set_flag); end
    n_checks++; if (set_time !== 17'd0 || alarm_time !== 17'd0 || alarm_flag !== 1'b0) begin n_fail++; $display("FAIL mid_reset_times: set_time %0d alarm_time %0d alarm_flag %0d expected 0 0 0", set_time, alarm_time, alarm_flag); end
    n_checks++; if (edit_hour !== 4'd12 || {edit_field, edit_min, edit_sec, edit_pm} !== 15'd0) begin n_fail++; $display("FAIL mid_reset_fields: hour %0d field %0d min %0d sec %0d pm %0d expected 12 0 0 0 0", edit_hour, edit_field, edit_min, edit_sec, edit_pm); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    n_checks++; if (set_flag !== 1'b0 || set_time !== 17'd0) begin n_fail++; $display("FAIL post_reset_idle: set_flag %0d set_time %0d expected 0 0", set_flag, set_time); end
  endtask

  initial begin
    test_reset;
    test_decode_latency;
    test_edit_commit;
    test_alarm_setup;
    test_alarm_edit;
    test_wraps;
    test_simultaneous;
    test_reset_mid_dec;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
